// File: rtl/jt51_mmr_q_pkg.sv
// Shared constants and types for the queued MMR front end: register map,
// default global/forwarded split and the queue entry layout.
package jt51_mmr_q_pkg;

  // Global register map
  localparam logic [7:0] REG_TEST   = 8'h01;
  localparam logic [7:0] REG_NOISE  = 8'h0F;
  localparam logic [7:0] REG_CLKA1  = 8'h10;
  localparam logic [7:0] REG_CLKA2  = 8'h11;
  localparam logic [7:0] REG_CLKB   = 8'h12;
  localparam logic [7:0] REG_TIMER  = 8'h14;
  localparam logic [7:0] REG_LFRQ   = 8'h18;
  localparam logic [7:0] REG_PMDAMD = 8'h19;
  localparam logic [7:0] REG_CTW    = 8'h1B;

  // Addresses below this are handled locally, never forwarded
  localparam logic [7:0] GLOBAL_LIMIT_DEF = 8'h20;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wq_entry_t;

  function automatic logic is_global(input logic [7:0] a, input logic [7:0] lim);
    return a < lim;
  endfunction

endpackage

// File: rtl/jt51_wfifo.sv
// Synchronous FIFO with clock enable. Head entry is presented from
// registered storage; the caller guarantees no push when full without a pop
// and no pop when empty.
module jt51_wfifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic [AW:0]   count,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^AW)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (cen) begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (cen && push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/jt51_mmr_q.sv
// Queued memory-mapped register front end for the JT51 core. Data-port
// writes are queued with the latched address; global registers are decoded
// locally as the queue drains, everything else is forwarded to the register
// file over a valid/ready handshake.
module jt51_mmr_q
  import jt51_mmr_q_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AW           = 2,
  parameter logic [7:0]  GLOBAL_LIMIT = GLOBAL_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [7:0]  d_in,
  input  logic        write,
  input  logic        a0,
  input  logic        lost_clr,
  output logic        busy,
  output logic        wr_lost,
  output logic [AW:0] level,
  output logic        upd_valid,
  output logic [7:0]  upd_addr,
  output logic [7:0]  upd_data,
  input  logic        upd_ready,
  output logic        ne,
  output logic [4:0]  nfrq,
  output logic [7:0]  lfo_freq,
  output logic [6:0]  lfo_amd,
  output logic [6:0]  lfo_pmd,
  output logic [1:0]  lfo_w,
  output logic        ct1,
  output logic        ct2,
  output logic        lfo_rst,
  output logic [9:0]  value_A,
  output logic [7:0]  value_B,
  output logic        enable_irq_A,
  output logic        enable_irq_B,
  output logic        load_A,
  output logic        load_B,
  output logic        clr_flag_A,
  output logic        clr_flag_B,
  output logic        set_run_A,
  output logic        set_run_B,
  output logic        clr_run_A,
  output logic        clr_run_B,
  output logic        csm
);

  logic [7:0]  addr_lat;
  logic [15:0] head_raw;
  wq_entry_t   head;
  logic        empty;
  logic        head_global;
  logic        exec_global;
  logic        fwd_pop;
  logic        pop;
  logic        data_wr;
  logic        push;
  logic        drop;
  logic [AW:0] next_count;

  jt51_wfifo #(
    .DW    (16),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wfifo (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .push  (push),
    .pop   (pop),
    .din   ({addr_lat, d_in}),
    .head  (head_raw),
    .count (level),
    .empty (empty)
  );

  assign head = wq_entry_t'(head_raw);

  // Head dispatch and push admission; a pop frees a slot for a same-cycle push
  always_comb begin
    head_global = !empty && is_global(head.addr, GLOBAL_LIMIT);
    upd_valid   = !empty && !head_global;
    upd_addr    = head.addr;
    upd_data    = head.data;
    exec_global = cen && head_global;
    fwd_pop     = cen && upd_valid && upd_ready;
    pop         = exec_global || fwd_pop;
    data_wr     = cen && write && a0;
    push        = data_wr && ((level != (AW+1)'(DEPTH)) || pop);
    drop        = data_wr && !push;
    next_count  = level;
    if (push && !pop) next_count = level + (AW+1)'(1);
    if (pop && !push) next_count = level - (AW+1)'(1);
  end

  // Address latch, busy flag and sticky lost-write flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lat <= '0;
      busy     <= 1'b0;
      wr_lost  <= 1'b0;
    end else if (cen) begin
      if (write && !a0) addr_lat <= d_in;
      busy <= (next_count == (AW+1)'(DEPTH));
      if (drop)          wr_lost <= 1'b1;
      else if (lost_clr) wr_lost <= 1'b0;
    end
  end

  // Global register decoder; pulse outputs hold for exactly one cen period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ne           <= 1'b0;
      nfrq         <= '0;
      lfo_freq     <= '0;
      lfo_amd      <= '0;
      lfo_pmd      <= '0;
      lfo_w        <= '0;
      ct1          <= 1'b0;
      ct2          <= 1'b0;
      lfo_rst      <= 1'b0;
      value_A      <= '0;
      value_B      <= '0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      set_run_A    <= 1'b0;
      set_run_B    <= 1'b0;
      clr_run_A    <= 1'b1;
      clr_run_B    <= 1'b1;
      csm          <= 1'b0;
    end else if (cen) begin
      lfo_rst    <= 1'b0;
      load_A     <= 1'b0;
      load_B     <= 1'b0;
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      set_run_A  <= 1'b0;
      set_run_B  <= 1'b0;
      clr_run_A  <= 1'b0;
      clr_run_B  <= 1'b0;
      csm        <= 1'b0;
      if (exec_global) begin
        case (head.addr)
          REG_TEST:  lfo_rst <= 1'b1;
          REG_NOISE: begin
            ne   <= head.data[7];
            nfrq <= head.data[4:0];
          end
          REG_CLKA1: value_A[9:2] <= head.data;
          REG_CLKA2: value_A[1:0] <= head.data[1:0];
          REG_CLKB:  value_B      <= head.data;
          REG_TIMER: begin
            csm          <= head.data[7];
            clr_flag_B   <= head.data[5];
            clr_flag_A   <= head.data[4];
            enable_irq_B <= head.data[3];
            enable_irq_A <= head.data[2];
            load_B       <= head.data[1];
            load_A       <= head.data[0];
            set_run_B    <= head.data[1];
            set_run_A    <= head.data[0];
            clr_run_B    <= ~head.data[1];
            clr_run_A    <= ~head.data[0];
          end
          REG_LFRQ: lfo_freq <= head.data;
          REG_PMDAMD: begin
            if (head.data[7]) lfo_pmd <= head.data[6:0];
            else              lfo_amd <= head.data[6:0];
          end
          REG_CTW: begin
            ct2   <= head.data[7];
            ct1   <= head.data[6];
            lfo_w <= head.data[1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt51_mmr_q.sv
// Directed bench for jt51_mmr_q: local decode latency, queue full/drop,
// ordering across forwarded and global entries, timer pulses, full-queue
// push with simultaneous pop, and asynchronous reset flush.
module tb_jt51_mmr_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic [7:0] d_in;
  logic       write;
  logic       a0;
  logic       lost_clr;
  logic       busy;
  logic       wr_lost;
  logic [2:0] level;
  logic       upd_valid;
  logic [7:0] upd_addr;
  logic [7:0] upd_data;
  logic       upd_ready;
  logic       ne;
  logic [4:0] nfrq;
  logic [7:0] lfo_freq;
  logic [6:0] lfo_amd;
  logic [6:0] lfo_pmd;
  logic [1:0] lfo_w;
  logic       ct1;
  logic       ct2;
  logic       lfo_rst;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       enable_irq_A;
  logic       enable_irq_B;
  logic       load_A;
  logic       load_B;
  logic       clr_flag_A;
  logic       clr_flag_B;
  logic       set_run_A;
  logic       set_run_B;
  logic       clr_run_A;
  logic       clr_run_B;
  logic       csm;

  int errors = 0;
  int checks = 0;

  jt51_mmr_q #(
    .DEPTH        (4),
    .AW           (2),
    .GLOBAL_LIMIT (8'h20)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cen          (cen),
    .d_in         (d_in),
    .write        (write),
    .a0           (a0),
    .lost_clr     (lost_clr),
    .busy         (busy),
    .wr_lost      (wr_lost),
    .level        (level),
    .upd_valid    (upd_valid),
    .upd_addr     (upd_addr),
    .upd_data     (upd_data),
    .upd_ready    (upd_ready),
    .ne           (ne),
    .nfrq         (nfrq),
    .lfo_freq     (lfo_freq),
    .lfo_amd      (lfo_amd),
    .lfo_pmd      (lfo_pmd),
    .lfo_w        (lfo_w),
    .ct1          (ct1),
    .ct2          (ct2),
    .lfo_rst      (lfo_rst),
    .value_A      (value_A),
    .value_B      (value_B),
    .enable_irq_A (enable_irq_A),
    .enable_irq_B (enable_irq_B),
    .load_A       (load_A),
    .load_B       (load_B),
    .clr_flag_A   (clr_flag_A),
    .clr_flag_B   (clr_flag_B),
    .set_run_A    (set_run_A),
    .set_run_B    (set_run_B),
    .clr_run_A    (clr_run_A),
    .clr_run_B    (clr_run_B),
    .csm          (csm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic port, input logic [7:0] val);
    write = 1'b1;
    a0    = port;
    d_in  = val;
    step();
    write = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cen       = 1'b1;
    d_in      = '0;
    write     = 1'b0;
    a0        = 1'b0;
    lost_clr  = 1'b0;
    upd_ready = 1'b0;
    #23;
    chk("rst_level", 16'(level), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_upd_valid", 16'(upd_valid), 16'h0);
    chk("rst_wr_lost", 16'(wr_lost), 16'h0);
    chk("rst_clr_run_A", 16'(clr_run_A), 16'h1);
    chk("rst_clr_run_B", 16'(clr_run_B), 16'h1);
    chk("rst_lfo_freq", 16'(lfo_freq), 16'h0);
    rst_n = 1'b1;
    step();
    chk("clr_run_A_drop", 16'(clr_run_A), 16'h0);

    // Global write on empty queue
    wr(1'b0, 8'h18);
    wr(1'b1, 8'h5A);
    chk("lfrq_pushed_level", 16'(level), 16'h1);
    chk("lfrq_not_yet", 16'(lfo_freq), 16'h0);
    chk("lfrq_no_upd", 16'(upd_valid), 16'h0);
    step();
    chk("lfrq_applied", 16'(lfo_freq), 16'h5A);
    chk("lfrq_level0", 16'(level), 16'h0);
    chk("lfrq_no_upd2", 16'(upd_valid), 16'h0);

    // cen=0 ignores writes
    cen = 1'b0;
    wr(1'b1, 8'h77);
    chk("cen0_level", 16'(level), 16'h0);
    cen = 1'b1;

    // Fill queue with forwarded entries, then overflow
    wr(1'b0, 8'h28);
    wr(1'b1, 8'hA0);
    chk("fwd_latency_valid", 16'(upd_valid), 16'h1);
    chk("fwd_latency_addr", 16'(upd_addr), 16'h28);
    wr(1'b1, 8'hA1);
    wr(1'b1, 8'hA2);
    wr(1'b1, 8'hA3);
    chk("full_busy", 16'(busy), 16'h1);
    chk("full_level", 16'(level), 16'h4);
    chk("full_lost0", 16'(wr_lost), 16'h0);
    wr(1'b1, 8'hA4);
    chk("ovf_lost", 16'(wr_lost), 16'h1);
    chk("ovf_level", 16'(level), 16'h4);
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 16'(upd_valid), 16'h1);
      chk("drain_data", 16'(upd_data), 16'(8'hA0 + i));
      step();
    end
    chk("drain_empty_valid", 16'(upd_valid), 16'h0);
    chk("drain_level", 16'(level), 16'h0);
    chk("drain_busy", 16'(busy), 16'h0);
    chk("lost_sticky", 16'(wr_lost), 16'h1);
    lost_clr = 1'b1;
    step();
    lost_clr = 1'b0;
    chk("lost_clr", 16'(wr_lost), 16'h0);

    // Ordering: global entry waits behind a stalled forwarded one
    upd_ready = 1'b0;
    wr(1'b0, 8'h28);
    wr(1'b1, 8'h11);
    wr(1'b0, 8'h12);
    wr(1'b1, 8'h7F);
    step();
    step();
    chk("order_level", 16'(level), 16'h2);
    chk("order_vb_held", 16'(value_B), 16'h0);
    upd_ready = 1'b1;
    chk("order_fwd_data", 16'(upd_data), 16'h11);
    step();
    upd_ready = 1'b0;
    chk("order_vb_still", 16'(value_B), 16'h0);
    chk("order_head_global", 16'(upd_valid), 16'h0);
    step();
    chk("order_vb", 16'(value_B), 16'h7F);
    chk("order_empty", 16'(level), 16'h0);

    // Timer control pulses
    wr(1'b0, 8'h14);
    wr(1'b1, 8'h05);
    step();
    chk("t1_load_A", 16'(load_A), 16'h1);
    chk("t1_set_run_A", 16'(set_run_A), 16'h1);
    chk("t1_clr_run_A", 16'(clr_run_A), 16'h0);
    chk("t1_clr_run_B", 16'(clr_run_B), 16'h1);
    chk("t1_irq_A", 16'(enable_irq_A), 16'h1);
    chk("t1_clr_flags", 16'({clr_flag_B, clr_flag_A}), 16'h0);
    step();
    chk("t1_pulses_off", 16'({load_A, set_run_A, clr_run_B, load_B, csm}), 16'h0);
    chk("t1_irq_A_level", 16'(enable_irq_A), 16'h1);
    wr(1'b1, 8'hBA);
    step();
    chk("t2_flags", 16'({clr_flag_B, clr_flag_A}), 16'h3);
    chk("t2_irq", 16'({enable_irq_B, enable_irq_A}), 16'h2);
    chk("t2_runs", 16'({set_run_B, set_run_A, clr_run_B, clr_run_A}), 16'h9);
    chk("t2_load", 16'({load_B, load_A, csm}), 16'h5);

    // Remaining global registers
    wr(1'b0, 8'h01);
    wr(1'b1, 8'h00);
    step();
    chk("lfo_rst_pulse", 16'(lfo_rst), 16'h1);
    step();
    chk("lfo_rst_clear", 16'(lfo_rst), 16'h0);
    wr(1'b0, 8'h10);
    wr(1'b1, 8'hAB);
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h03);
    step();
    chk("value_A", 16'(value_A), 16'h2AF);
    wr(1'b0, 8'h19);
    wr(1'b1, 8'h85);
    wr(1'b1, 8'h12);
    step();
    chk("lfo_pmd", 16'(lfo_pmd), 16'h05);
    chk("lfo_amd", 16'(lfo_amd), 16'h12);
    wr(1'b0, 8'h1B);
    wr(1'b1, 8'hC2);
    step();
    chk("ctw", 16'({ct2, ct1, lfo_w}), 16'hE);
    wr(1'b0, 8'h0F);
    wr(1'b1, 8'h9F);
    step();
    chk("noise", 16'({ne, nfrq}), 16'h3F);
    wr(1'b0, 8'h1F);
    wr(1'b1, 8'hFF);
    step();
    chk("unknown_global_popped", 16'(level), 16'h0);
    chk("unknown_no_upd", 16'(upd_valid), 16'h0);

    // Push into a full queue with a same-cycle pop
    wr(1'b0, 8'h28);
    wr(1'b1, 8'hB0);
    wr(1'b1, 8'hB1);
    wr(1'b1, 8'hB2);
    wr(1'b1, 8'hB3);
    chk("full2_level", 16'(level), 16'h4);
    upd_ready = 1'b1;
    wr(1'b1, 8'hB4);
    chk("full2_accept_level", 16'(level), 16'h4);
    chk("full2_no_lost", 16'(wr_lost), 16'h0);
    chk("full2_busy", 16'(busy), 16'h1);
    chk("full2_head", 16'(upd_data), 16'hB1);
    step();
    upd_ready = 1'b0;
    chk("pre_rst_level", 16'(level), 16'h3);
    chk("pre_rst_valid", 16'(upd_valid), 16'h1);

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_upd_valid", 16'(upd_valid), 16'h0);
    chk("arst_level", 16'(level), 16'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_level", 16'(level), 16'h0);
    chk("post_rst_clr_run_A", 16'(clr_run_A), 16'h1);
    chk("post_rst_lfo_freq", 16'(lfo_freq), 16'h0);
    step();
    chk("post_rst_idle", 16'(upd_valid), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
